// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_sequencer_pkg;
  `include "pll_seq_defs.vh"

  // Encoding 3 is unused; it is named so a corrupted state register can be decoded and recovered.
  typedef enum logic [1:0] {
    S_HOLD      = ST_HOLD,
    S_WAIT_LOCK = ST_WAIT_LOCK,
    S_RUN       = ST_RUN,
    S_ILLEGAL   = 2'd3
  } seq_state_t;

  // Internal counter width: wide enough for the largest cycle count so counters never wrap.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/pll_seq_defs.vh
// State encodings shared by the PLL reset sequencer and anything that decodes its STATE output.
`ifndef PLL_SEQ_DEFS_VH
`define PLL_SEQ_DEFS_VH
localparam logic [1:0] ST_HOLD      = 2'd0;
localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
localparam logic [1:0] ST_RUN       = 2'd2;
`endif

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing an asynchronous level into the local clock domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  // Shift the input through two flops; both clear to 0 while reset is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up/recovery sequencer: holds the PLL in reset, waits for a stable lock, releases the
// fabric reset, retries on lock timeout and re-sequences on a filtered loss of lock.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOSS_FILTER         = 4,
  parameter int CNT_W               = 8
) (
  input  logic             referenceclk,
  input  logic             reset,
  input  logic             lock,
  input  logic             clr_counts,
  output logic             pll_resetb,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] loss_count
);
  import pll_reset_sequencer_pkg::*;

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES, LOSS_FILTER);
  localparam logic [CW-1:0]    HOLD_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0]    STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]    TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    LOSS_LAST    = CW'(LOSS_FILTER - 1);
  localparam logic [CW-1:0]    ONE          = CW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    hold_cnt, hold_d;
  logic [CW-1:0]    stable_cnt, stable_d;
  logic [CW-1:0]    to_cnt, to_d;
  logic [CW-1:0]    loss_cnt, loss_d;
  logic [CNT_W-1:0] retry_d, losses_d;
  logic             retry_inc, loss_inc;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk (referenceclk),
    .rst (reset),
    .d   (lock),
    .q   (lock_s)
  );

  assign state = state_q;

  // Register state, counters and outputs together so outputs change on the same edge as the state.
  always_ff @(posedge referenceclk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HOLD;
      hold_cnt    <= '0;
      stable_cnt  <= '0;
      to_cnt      <= '0;
      loss_cnt    <= '0;
      retry_count <= '0;
      loss_count  <= '0;
      pll_resetb  <= 1'b0;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt    <= hold_d;
      stable_cnt  <= stable_d;
      to_cnt      <= to_d;
      loss_cnt    <= loss_d;
      retry_count <= retry_d;
      loss_count  <= losses_d;
      pll_resetb  <= (state_d != S_HOLD);
      sys_reset   <= (state_d != S_RUN);
      ready       <= (state_d == S_RUN);
    end
  end

  // Next-state and counter logic; stable completion takes priority over a same-cycle timeout.
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_cnt;
    stable_d  = stable_cnt;
    to_d      = to_cnt;
    loss_d    = loss_cnt;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_d = S_WAIT_LOCK;
          hold_d  = '0;
        end else begin
          hold_d = hold_cnt + ONE;
        end
      end
      S_WAIT_LOCK: begin
        stable_d = lock_s ? stable_cnt + ONE : '0;
        to_d     = to_cnt + ONE;
        if (lock_s && (stable_cnt == STABLE_LAST)) begin
          state_d  = S_RUN;
          stable_d = '0;
          to_d     = '0;
        end else if (to_cnt == TIMEOUT_LAST) begin
          state_d   = S_HOLD;
          stable_d  = '0;
          to_d      = '0;
          retry_inc = 1'b1;
        end
      end
      S_RUN: begin
        if (lock_s) begin
          loss_d = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_d  = S_HOLD;
          loss_d   = '0;
          loss_inc = 1'b1;
        end else begin
          loss_d = loss_cnt + ONE;
        end
      end
      default: begin
        state_d  = S_HOLD;
        hold_d   = '0;
        stable_d = '0;
        to_d     = '0;
        loss_d   = '0;
      end
    endcase

    retry_d  = retry_count;
    losses_d = loss_count;
    if (clr_counts) begin
      retry_d  = '0;
      losses_d = '0;
    end else begin
      if (retry_inc && (retry_count != CNT_MAX)) retry_d = retry_count + CNT_ONE;
      if (loss_inc && (loss_count != CNT_MAX)) losses_d = loss_count + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer using small parameters and hand-derived edge numbers.
module tb_pll_reset_sequencer;
  logic       clock;
  logic       reset;
  logic       lock;
  logic       clr_counts;
  logic       pll_resetb;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [1:0] retry_count;
  logic [1:0] loss_count;

  int checks = 0;
  int errors = 0;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOSS_FILTER         (3),
    .CNT_W               (2)
  ) dut (
    .referenceclk (clock),
    .reset        (reset),
    .lock         (lock),
    .clr_counts   (clr_counts),
    .pll_resetb   (pll_resetb),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .state        (state),
    .retry_count  (retry_count),
    .loss_count   (loss_count)
  );

  // Free-running reference clock, 10 ns period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic r, input logic l, input logic c);
    reset      = r;
    lock       = l;
    clr_counts = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Hold reset for two edges, then release 1 ns after an edge; the next posedge is edge 1.
  task automatic doReset(input logic l);
    applyStimulus(1'b1, l, 1'b0);
    waitEdges(2);
    reset = 1'b0;
  endtask

  // With LOCK high: PLL_RESETB rises at edge 4, READY at edge 12.
  task automatic checkPowerUp(input string pfx);
    waitEdges(3);
    checkOutput({pfx, "_e3_resetb"}, pll_resetb, 0);
    checkOutput({pfx, "_e3_state"}, state, 0);
    waitEdges(1);
    checkOutput({pfx, "_e4_resetb"}, pll_resetb, 1);
    checkOutput({pfx, "_e4_state"}, state, 1);
    checkOutput({pfx, "_e4_sysreset"}, sys_reset, 1);
    waitEdges(7);
    checkOutput({pfx, "_e11_sysreset"}, sys_reset, 1);
    checkOutput({pfx, "_e11_ready"}, ready, 0);
    waitEdges(1);
    checkOutput({pfx, "_e12_sysreset"}, sys_reset, 0);
    checkOutput({pfx, "_e12_ready"}, ready, 1);
    checkOutput({pfx, "_e12_state"}, state, 2);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitEdges(2);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_resetb", pll_resetb, 0);
    checkOutput("rst_sysreset", sys_reset, 1);
    checkOutput("rst_ready", ready, 0);
    checkOutput("rst_retry", retry_count, 0);
    checkOutput("rst_loss", loss_count, 0);
    reset = 1'b0;
    checkPowerUp("t1");

    // Two synced-low cycles in RUN are filtered out.
    lock = 1'b0;
    waitEdges(2);
    lock = 1'b1;
    waitEdges(4);
    checkOutput("t4_short_state", state, 2);
    checkOutput("t4_short_loss", loss_count, 0);
    checkOutput("t4_short_ready", ready, 1);

    // Three synced-low cycles: HOLD on the third, 5 edges after LOCK drops.
    lock = 1'b0;
    waitEdges(3);
    lock = 1'b1;
    waitEdges(1);
    checkOutput("t4_long_pre_state", state, 2);
    waitEdges(1);
    checkOutput("t4_long_state", state, 0);
    checkOutput("t4_long_sysreset", sys_reset, 1);
    checkOutput("t4_long_resetb", pll_resetb, 0);
    checkOutput("t4_long_ready", ready, 0);
    checkOutput("t4_long_loss", loss_count, 1);

    // Re-sequences back to RUN, then an asynchronous reset between edges aborts at once.
    waitEdges(20);
    checkOutput("t6_run_state", state, 2);
    checkOutput("t6_run_loss", loss_count, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_sysreset", sys_reset, 1);
    checkOutput("t6_async_resetb", pll_resetb, 0);
    checkOutput("t6_async_ready", ready, 0);
    checkOutput("t6_async_loss", loss_count, 0);
    checkOutput("t6_async_state", state, 0);
    #2;
    reset = 1'b0;
    checkPowerUp("t6");

    // LOCK low only at edge 8: stable count restarts, RUN moves from edge 12 to 18.
    doReset(1'b1);
    waitEdges(7);
    lock = 1'b0;
    waitEdges(1);
    lock = 1'b1;
    waitEdges(4);
    checkOutput("t3_e12_state", state, 1);
    waitEdges(5);
    checkOutput("t3_e17_state", state, 1);
    waitEdges(1);
    checkOutput("t3_e18_state", state, 2);
    checkOutput("t3_e18_ready", ready, 1);

    // LOCK never arrives: timeouts at edges 36, 72, 108, 144 with saturating retries.
    doReset(1'b0);
    waitEdges(35);
    checkOutput("t2_e35_state", state, 1);
    checkOutput("t2_e35_retry", retry_count, 0);
    waitEdges(1);
    checkOutput("t2_e36_state", state, 0);
    checkOutput("t2_e36_resetb", pll_resetb, 0);
    checkOutput("t2_e36_retry", retry_count, 1);
    waitEdges(3);
    checkOutput("t2_e39_resetb", pll_resetb, 0);
    waitEdges(1);
    checkOutput("t2_e40_resetb", pll_resetb, 1);
    checkOutput("t2_e40_state", state, 1);
    waitEdges(32);
    checkOutput("t2_e72_retry", retry_count, 2);
    checkOutput("t2_e72_state", state, 0);
    waitEdges(36);
    checkOutput("t2_e108_retry", retry_count, 3);
    waitEdges(36);
    checkOutput("t2_e144_retry", retry_count, 3);
    checkOutput("t2_e144_state", state, 0);

    // CLR_COUNTS on the edge of the next timeout (edge 180) wins over the increment.
    waitEdges(35);
    checkOutput("t5_e179_retry", retry_count, 3);
    checkOutput("t5_e179_state", state, 1);
    clr_counts = 1'b1;
    waitEdges(1);
    clr_counts = 1'b0;
    checkOutput("t5_e180_retry", retry_count, 0);
    checkOutput("t5_e180_state", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
